// File: rtl/multicycle_controller.sv
// Multicycle RISC-style control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// a memory-wait timeout that parks the machine in a sticky FAULT state.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic        branch,
    input  logic        regWrite,
    input  logic        JAL,
    input  logic        JALR,
    input  logic        AUIPC,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d, wait_nxt;
    logic          ld_q, st_q, br_q, rw_q, jal_q, jalr_q, auipc_q, taken_q;
    logic          ld_d, st_d, br_d, rw_d, jal_d, jalr_d, auipc_d, taken_d;
    logic [31:0]   instr_count_q;

    logic          retire, wait_inc, taken_now;
    logic          ir_c, req_c, we_c, sel_c, rw_c;
    logic [1:0]    src_c;

    // AUIPC only matters through regWrite; its latched copy is kept for state visibility.
    logic unused_auipc;
    assign unused_auipc = auipc_q;

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        st_d     = st_q;
        br_d     = br_q;
        rw_d     = rw_q;
        jal_d    = jal_q;
        jalr_d   = jalr_q;
        auipc_d  = auipc_q;
        taken_d  = taken_q;
        ir_c     = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        sel_c    = 1'b0;
        rw_c     = 1'b0;
        retire   = 1'b0;
        wait_inc = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_c    = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                ld_d    = load;
                st_d    = store;
                br_d    = branch;
                rw_d    = regWrite;
                jal_d   = JAL;
                jalr_d  = JALR;
                auipc_d = AUIPC;
                if ((load && store) || (JAL && JALR)) state_d = S_FAULT;
                else                                  state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                taken_d = branch_taken;
                if (ld_q || st_q) begin
                    state_d = S_MEM;
                end else if (rw_q) begin
                    state_d = S_WB;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                req_c = 1'b1;
                sel_c = 1'b1;
                we_c  = st_q;
                if (mem_ready) begin
                    if (st_q) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                rw_c    = rw_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // The timeout takes priority over staying put in the waiting state.
        wait_nxt = wait_q + WW'(1);
        if (wait_inc && (wait_nxt == WW'(TIMEOUT_CYCLES))) state_d = S_FAULT;

        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) wait_d = '0;
        else if (wait_inc)                                                          wait_d = wait_nxt;
        else                                                                        wait_d = wait_q;

        taken_now = (state_q == S_EXECUTE) ? branch_taken : taken_q;
        if (!retire)                        src_c = 2'd0;
        else if (jalr_q)                    src_c = 2'd2;
        else if (jal_q || (br_q && taken_now)) src_c = 2'd1;
        else                                src_c = 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            ld_q          <= 1'b0;
            st_q          <= 1'b0;
            br_q          <= 1'b0;
            rw_q          <= 1'b0;
            jal_q         <= 1'b0;
            jalr_q        <= 1'b0;
            auipc_q       <= 1'b0;
            taken_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            br_q    <= br_d;
            rw_q    <= rw_d;
            jal_q   <= jal_d;
            jalr_q  <= jalr_d;
            auipc_q <= auipc_d;
            taken_q <= taken_d;
            if (retire) instr_count_q <= instr_count_q + 32'd1;
        end
    end

    // Outputs are Mealy (ir_write/pc_write follow mem_ready) and forced low while reset is high.
    assign ir_write    = ir_c & ~reset;
    assign pc_write    = retire & ~reset;
    assign reg_write   = rw_c & ~reset;
    assign mem_req     = req_c & ~reset;
    assign mem_we      = we_c & ~reset;
    assign mem_sel     = sel_c & ~reset;
    assign pc_src      = reset ? 2'd0 : src_c;
    assign fault       = (state_q == S_FAULT) & ~reset;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, corner-case sequences,
// and random instructions checked against a per-instruction cycle-trace model.
module tb_multicycle_controller;

    logic        clk, reset;
    logic        load, store, branch, regWrite, JAL, JALR, AUIPC;
    logic        branch_taken, mem_ready;
    logic        ir_write, pc_write, reg_write, mem_req, mem_we, mem_sel;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instr_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_cnt = 32'd0;

    // Flag vectors are ordered {load, store, branch, regWrite, JAL, JALR, AUIPC}.
    typedef struct {
        logic [6:0] flags;
        logic       bt;
        int         lat;
        logic [1:0] src;
        logic       rw;
    } vec_t;

    typedef struct {
        logic [6:0]  flags;
        logic        bt;
        logic        rdy;
        logic [31:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t exp_q[$];
    vec_t vecs[11];

    multicycle_controller #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .load(load), .store(store), .branch(branch), .regWrite(regWrite),
        .JAL(JAL), .JALR(JALR), .AUIPC(AUIPC),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .pc_src(pc_src), .state(state), .fault(fault), .instr_count(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pk(int s, int ir, int pcw, int rw, int req, int we, int sel, int src, int flt);
        return {20'd0, 3'(s), 1'(ir), 1'(pcw), 1'(rw), 1'(req), 1'(we), 1'(sel), 2'(src), 1'(flt)};
    endfunction

    function automatic logic [31:0] act_out();
        return {20'd0, state, ir_write, pc_write, reg_write, mem_req, mem_we, mem_sel, pc_src, fault};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] f, input logic bt, input logic rdy);
        @(negedge clk);
        {load, store, branch, regWrite, JAL, JALR, AUIPC} = f;
        branch_taken = bt;
        mem_ready    = rdy;
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        {load, store, branch, regWrite, JAL, JALR, AUIPC} = 7'd0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        #1;
        check("rst_out", act_out(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rst_cnt", instr_count, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_cnt = 32'd0;
        #1;
        check("rst_first_req", act_out(), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    endtask

    task automatic run_instr(input logic [6:0] f, input logic bt, output int lat,
                             output logic [1:0] src, output logic rw_seen);
        lat = 0;
        src = 2'd3;
        rw_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(f, bt, 1'b1);
            lat++;
            rw_seen = rw_seen | reg_write;
            if (pc_write) begin
                src = pc_src;
                break;
            end
            if (fault) break;
        end
    endtask

    task automatic push(input logic [6:0] f, input logic bt, input logic rdy, input logic [31:0] e);
        cyc_t r;
        r.flags = f;
        r.bt    = bt;
        r.rdy   = rdy;
        r.exp   = e;
        r.cnt   = m_cnt;
        exp_q.push_back(r);
    endtask

    // Expected cycle trace of one instruction: fetch stalls sf, memory stalls sm.
    task automatic build_instr(input logic [6:0] f, input logic bt, input int sf, input int sm);
        logic ld, st, br, rw, jal, jalr, mem;
        int   src;
        {ld, st, br, rw, jal, jalr} = f[6:1];
        mem = ld | st;
        src = jalr ? 2 : ((jal || (br && bt)) ? 1 : 0);
        for (int i = 0; i < sf; i++) push(f, rnd1(), 1'b0, pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        push(f, rnd1(), 1'b1, pk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        push(f, rnd1(), rnd1(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!mem && !rw) begin
            push(rnd7(), bt, rnd1(), pk(2, 0, 1, 0, 0, 0, 0, src, 0));
            m_cnt++;
        end else begin
            push(rnd7(), bt, rnd1(), pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        if (mem) begin
            for (int i = 0; i < sm; i++) push(rnd7(), rnd1(), 1'b0, pk(3, 0, 0, 0, 1, st, 1, 0, 0));
            if (st) begin
                push(rnd7(), rnd1(), 1'b1, pk(3, 0, 1, 0, 1, 1, 1, src, 0));
                m_cnt++;
            end else begin
                push(rnd7(), rnd1(), 1'b1, pk(3, 0, 0, 0, 1, 0, 1, 0, 0));
            end
        end
        if ((mem && !st) || (!mem && rw)) begin
            push(rnd7(), rnd1(), rnd1(), pk(4, 0, 1, rw, 0, 0, 0, src, 0));
            m_cnt++;
        end
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int         lat, mem_cycles, tot, sf, sm;
        logic [1:0] src;
        logic       rws, done, bt;
        logic [6:0] f;
        cyc_t       r;

        vecs[0]  = '{7'b0001000, 1'b0, 4, 2'd0, 1'b1};
        vecs[1]  = '{7'b0010000, 1'b1, 3, 2'd1, 1'b0};
        vecs[2]  = '{7'b0010000, 1'b0, 3, 2'd0, 1'b0};
        vecs[3]  = '{7'b0001100, 1'b0, 4, 2'd1, 1'b1};
        vecs[4]  = '{7'b0001010, 1'b0, 4, 2'd2, 1'b1};
        vecs[5]  = '{7'b0001001, 1'b0, 4, 2'd0, 1'b1};
        vecs[6]  = '{7'b0100000, 1'b0, 4, 2'd0, 1'b0};
        vecs[7]  = '{7'b1001000, 1'b0, 5, 2'd0, 1'b1};
        vecs[8]  = '{7'b0000000, 1'b0, 3, 2'd0, 1'b0};
        vecs[9]  = '{7'b0010010, 1'b1, 3, 2'd2, 1'b0};
        vecs[10] = '{7'b0000100, 1'b0, 3, 2'd1, 1'b0};

        reset = 1'b1;
        {load, store, branch, regWrite, JAL, JALR, AUIPC} = 7'd0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        do_reset();

        for (int v = 0; v < 11; v++) begin
            run_instr(vecs[v].flags, vecs[v].bt, lat, src, rws);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("vec%0d_pc_src", v), 32'(src), 32'(vecs[v].src));
            check($sformatf("vec%0d_reg_write", v), 32'(rws), 32'(vecs[v].rw));
            @(posedge clk);
            #1;
            m_cnt++;
            check($sformatf("vec%0d_count", v), instr_count, m_cnt);
        end

        // Load whose data access is unanswered for three cycles.
        mem_cycles = 0;
        tot = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(7'b1001000, 1'b0, !(i >= 3 && i <= 5));
            tot++;
            if (state == 3'd3) begin
                mem_cycles++;
                check("ld_mem_signals", 32'({mem_req, mem_sel, mem_we}), 32'(3'b110));
            end
            if (pc_write) begin
                check("ld_wb_out", act_out(), pk(4, 0, 1, 1, 0, 0, 0, 0, 0));
                done = 1'b1;
            end
        end
        check("ld_mem_cycles", 32'(mem_cycles), 32'd4);
        check("ld_total", 32'(tot), 32'd8);
        @(posedge clk);
        #1;
        m_cnt++;
        check("ld_count", instr_count, m_cnt);

        // Illegal flag combinations trap in DECODE.
        drive(7'b1100000, 1'b0, 1'b1);
        drive(7'b1100000, 1'b0, 1'b1);
        check("ill_ldst_decode", act_out(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(7'b1100000, 1'b0, 1'b1);
        check("ill_ldst_fault", act_out(), pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        do_reset();
        drive(7'b0000110, 1'b0, 1'b1);
        drive(7'b0000110, 1'b0, 1'b1);
        drive(7'b0000110, 1'b0, 1'b1);
        check("ill_jal_fault", act_out(), pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        do_reset();

        // Reset arriving mid-MEM clears outputs before any clock edge.
        drive(7'b1001000, 1'b0, 1'b1);
        drive(7'b1001000, 1'b0, 1'b1);
        drive(7'b1001000, 1'b0, 1'b1);
        drive(7'b1001000, 1'b0, 1'b0);
        check("midmem_before", act_out(), pk(3, 0, 0, 0, 1, 0, 1, 0, 0));
        do_reset();

        // Fetch timeout and sticky FAULT.
        for (int i = 0; i < 15; i++) begin
            drive(7'd0, 1'b0, 1'b0);
            check("to_waiting", act_out(), pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        drive(7'd0, 1'b0, 1'b0);
        check("to_fault", act_out(), pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            drive(rnd7(), rnd1(), 1'b1);
            check("to_sticky", act_out(), pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        do_reset();

        // Retired-instruction counter wrap.
        dut.instr_count_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            run_instr(7'b0001000, 1'b0, lat, src, rws);
            @(posedge clk);
            #1;
            m_cnt++;
            check($sformatf("wrap_count%0d", k), instr_count, m_cnt);
        end

        // Random instruction stream against the trace model.
        for (int n = 0; n < 150; n++) begin
            f = rnd7();
            if (f[6] && f[5]) f[$urandom_range(5, 6)] = 1'b0;
            if (f[2] && f[1]) f[$urandom_range(1, 2)] = 1'b0;
            bt = rnd1();
            sf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            sm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            build_instr(f, bt, sf, sm);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                drive(r.flags, r.bt, r.rdy);
                check("rnd_out", act_out(), r.exp);
                check("rnd_count", instr_count, r.cnt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the number of consecutive unanswered memory-request cycles that forces FAULT.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports load, store, branch, regWrite, JAL, JALR, AUIPC  input  1 each  decode flags from main_decoder for the current IR.
REQ-005 SHALL have port branch_taken  input  1  branch comparison result, valid in EXECUTE.
REQ-006 SHALL have port mem_ready  input  1  memory acknowledge for the current mem_req.
REQ-007 SHALL have ports ir_write, pc_write, reg_write, mem_req, mem_we, mem_sel  output  1 each  IR load, PC update, register-file write, memory request, memory write, and memory select (0 = instruction, 1 = data).
REQ-008 SHALL have port pc_src  output  2  next-PC select: 0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
REQ-009 SHALL have ports state  output  3  current state, and fault  output  1  sticky error flag.
REQ-010 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=5; codes 6-7 SHALL go to FAULT on the next edge.
REQ-012 FETCH: mem_req=1, mem_sel=0; when mem_ready=1, assert ir_write in that same cycle and go to DECODE; otherwise stay in FETCH.
REQ-013 DECODE: lasts one cycle and latches all REQ-004 flags into internal registers; every later state uses only the latched copies.
REQ-014 DECODE: if (load & store) or (JAL & JALR), go to FAULT instead of EXECUTE.
REQ-015 EXECUTE: lasts one cycle and samples branch_taken.
- load|store -> MEM.
- else regWrite -> WRITEBACK.
- else retire: pc_write=1 this cycle, then FETCH.
REQ-016 MEM: mem_req=1, mem_sel=1, mem_we=latched store.
- Stay in MEM until mem_ready.
- On mem_ready with load: go to WRITEBACK.
- On mem_ready with store: retire (pc_write=1), then FETCH.
REQ-017 WRITEBACK: reg_write=latched regWrite, pc_write=1, then FETCH; lasts exactly one cycle.
REQ-018 On every retire cycle, pc_src SHALL be:
- 2 if JALR;
- else 1 if JAL, or branch with sampled branch_taken;
- else 0.
REQ-019 pc_src SHALL be 0 in all non-retire cycles.
REQ-020 All outputs not listed for a state SHALL be 0 in that state.
REQ-021 Latency with mem_ready held at 1: branch/no-write = 3 cycles, ALU/JAL/JALR/AUIPC = 4, store = 4, load = 5, counted from FETCH entry to FETCH re-entry.
REQ-022 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle that mem_req=1 and mem_ready=0.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES, the next state SHALL be FAULT.
REQ-024 FAULT: fault=1 and all enables/requests 0; FAULT is exited only by reset.
REQ-025 instr_count SHALL increment by 1 on each cycle with pc_write=1 and wrap from 0xFFFFFFFF to 0.

Reset
REQ-026 While reset=1: state=FETCH, all outputs 0 (including mem_req), instr_count=0, fault=0, wait counter=0, latched flags 0.
REQ-027 Reset asserted in any state, including mid-MEM or FAULT, SHALL take effect immediately without waiting for a clock edge.
REQ-028 The first mem_req SHALL be asserted in the first cycle after reset deasserts.

Verification
REQ-029 ALU instruction (regWrite=1 only), mem_ready=1 -> states 0,1,2,4,0; reg_write and pc_write high in WRITEBACK; pc_src=0; instr_count 0->1.
REQ-030 Load with mem_ready low for 3 MEM cycles -> MEM held 4 cycles with mem_sel=1 and mem_we=0; then WRITEBACK; total 8 cycles.
REQ-031 Branch with branch_taken=1 -> retire in EXECUTE, pc_src=1, no reg_write, 3 cycles; with branch_taken=0 -> pc_src=0.
REQ-032 JALR with regWrite=1 -> pc_src=2 and reg_write=1 in WRITEBACK.
REQ-033 mem_ready held 0 in FETCH -> state=5 and fault=1 after 15 wait cycles; holding it does not recover; reset -> state=0, fault=0.
REQ-034 load=store=1 at DECODE -> FAULT; reset asserted mid-MEM -> all outputs 0 asynchronously; instr_count preloaded near 0xFFFFFFFF wraps to 0.
